// File: rtl/line_memory_responder.sv
// Fixed-latency 256-bit line memory answering the data-cache mem_* bus.
// Define LMR_PROTOCOL_CHECK_EN to flag initiators that change a held request.
module line_memory_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o,
  output logic              proto_err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]        count;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_in;
  logic              commit;

  logic [LINE_W-1:0] mem [DEPTH];

  assign idx_in = mem_addr_i[5 +: IDX_W];
  assign commit = (state == BUSY) && (count == 8'(LATENCY));

  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[ADDR_W-1:5+IDX_W], mem_addr_i[4:0]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mem_enable_i) state_nxt = BUSY;
      BUSY: if (commit) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      count      <= 8'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      state     <= state_nxt;
      mem_ack_o <= commit;
      if (state == IDLE && mem_enable_i) begin
        wr_q   <= mem_write_i;
        idx_q  <= idx_in;
        data_q <= mem_data_i;
        count  <= 8'd1;
      end else if (state == BUSY && !commit) begin
        count <= count + 8'd1;
      end
      if (commit && !wr_q) mem_data_o <= mem[idx_q];
    end
  end

  // Array is deliberately not reset; an aborted request never reaches commit.
  always_ff @(posedge clk_i) begin
    if (commit && wr_q) mem[idx_q] <= data_q;
  end

`ifdef LMR_PROTOCOL_CHECK_EN
  logic err_q;
  logic mismatch;

  assign mismatch = !mem_enable_i
                 || (mem_write_i != wr_q)
                 || (idx_in != idx_q)
                 || (wr_q && (mem_data_i != data_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else if (state == BUSY && mismatch) err_q <= 1'b1;
  end

  assign proto_err_o = err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: latency, data, aliasing,
// spacing, reset abort and protocol flag.
module tb_line_memory_responder;

  localparam int LAT = 10;
`ifdef LMR_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk_i = 0;
  logic         rst_i = 0;
  logic         mem_enable_i = 0;
  logic         mem_write_i = 0;
  logic [31:0]  mem_addr_i = '0;
  logic [255:0] mem_data_i = '0;
  logic [255:0] mem_data_o;
  logic         mem_ack_o;
  logic         proto_err_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [255:0] exp_q[$];

  line_memory_responder #(
    .LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_enable_i(mem_enable_i), .mem_write_i(mem_write_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_ack_o(mem_ack_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one request from IDLE, waits for ack, returns latency and data.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [255:0] d, output int lat,
                       output logic [255:0] rd, output logic one_cycle);
    @(negedge clk_i);
    mem_enable_i = 1; mem_write_i = wr;
    mem_addr_i = addr; mem_data_i = d;
    @(posedge clk_i);
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk_i); #1;
      if (mem_ack_o) begin lat = n; break; end
    end
    rd = mem_data_o;
    mem_enable_i = 0;
    @(posedge clk_i); #1;
    one_cycle = !mem_ack_o;
  endtask

  task automatic test_reset();
    rst_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (mem_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack got %b want 0", mem_ack_o);
    end
    n_checks++;
    if (mem_data_o !== 256'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", mem_data_o);
    end
    n_checks++;
    if (proto_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", proto_err_o);
    end
    @(negedge clk_i); rst_i = 1;
  endtask

  task automatic test_write();
    int lat; logic [255:0] rd; logic one; logic [255:0] e;
    exp_q.push_back(256'h0);
    issue(1'b1, 32'h40, {32{8'hA5}}, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL wr_latency got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (!one) begin n_fail++; $display("FAIL wr_pulse got 2+ cycles want 1"); end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL wr_data_o got %h want %h", rd, e); end
    n_checks++;
    if (proto_err_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_err got %b want 0", proto_err_o);
    end
  endtask

  task automatic test_read();
    int lat; logic [255:0] rd; logic one; logic [255:0] e;
    exp_q.push_back({32{8'hA5}});
    issue(1'b0, 32'h40, 256'h0, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL rd_data got %h want %h", rd, e); end
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (mem_data_o !== e) begin
      n_fail++; $display("FAIL rd_hold got %h want %h", mem_data_o, e);
    end
  endtask

  task automatic test_alias();
    int lat; logic [255:0] rd; logic one; logic [255:0] e;
    exp_q.push_back({32{8'hA5}});
    issue(1'b1, 32'h4040, {8{32'hDEADBEEF}}, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL alias_wr_keep got %h want %h", rd, e); end
    exp_q.push_back({8{32'hDEADBEEF}});
    issue(1'b0, 32'h40, 256'h0, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL alias_rd got %h want %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    int first; int second; int extra;
    first = -1; second = -1; extra = 0;
    @(negedge clk_i);
    mem_enable_i = 1; mem_write_i = 0; mem_addr_i = 32'h40;
    @(posedge clk_i);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i); #1;
      if (mem_ack_o) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
        else extra++;
      end
      if (second >= 0) mem_enable_i = 0;
    end
    n_checks++;
    if (first !== LAT) begin
      n_fail++; $display("FAIL b2b_first got %0d want %0d", first, LAT);
    end
    n_checks++;
    if (second !== 2 * LAT + 2) begin
      n_fail++; $display("FAIL b2b_second got %0d want %0d", second, 2 * LAT + 2);
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [255:0] rd; logic one; logic [255:0] e; int acks;
    issue(1'b1, 32'hA0, {8{32'h11112222}}, lat, rd, one);
    @(negedge clk_i);
    mem_enable_i = 1; mem_write_i = 1;
    mem_addr_i = 32'hA0; mem_data_i = {8{32'h33334444}};
    @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    #1;
    n_checks++;
    if (mem_ack_o !== 1'b0 || mem_data_o !== 256'h0) begin
      n_fail++; $display("FAIL abort_outputs got ack=%b data=%h want 0/0", mem_ack_o, mem_data_o);
    end
    @(negedge clk_i); mem_enable_i = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (mem_ack_o) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL abort_ack got %0d want 0", acks); end
    exp_q.push_back({8{32'h11112222}});
    issue(1'b0, 32'hA0, 256'h0, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL abort_keep got %h want %h", rd, e); end
  endtask

  task automatic test_protocol();
    int lat; logic [255:0] rd; logic one; logic [255:0] e;
    issue(1'b1, 32'h80, {8{32'h55556666}}, lat, rd, one);
    @(negedge clk_i);
    mem_enable_i = 1; mem_write_i = 1;
    mem_addr_i = 32'h60; mem_data_i = {8{32'h77778888}};
    @(posedge clk_i);
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk_i); #1;
      if (n == 2) mem_addr_i = 32'h80;
      if (mem_ack_o) begin lat = n; break; end
    end
    mem_enable_i = 0;
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL proto_latency got %0d want %0d", lat, LAT);
    end
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (proto_err_o !== EXP_ERR) begin
      n_fail++; $display("FAIL proto_err got %b want %b", proto_err_o, EXP_ERR);
    end
    exp_q.push_back({8{32'h77778888}});
    issue(1'b0, 32'h60, 256'h0, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL proto_captured got %h want %h", rd, e); end
    exp_q.push_back({8{32'h55556666}});
    issue(1'b0, 32'h80, 256'h0, lat, rd, one);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL proto_other got %h want %h", rd, e); end
    n_checks++;
    if (proto_err_o !== EXP_ERR) begin
      n_fail++; $display("FAIL proto_sticky got %b want %b", proto_err_o, EXP_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alias();
    test_back_to_back();
    test_reset_abort();
    test_protocol();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
